// File: rtl/io_util_pkg.sv
// Shared constants and helpers for the board I/O utility block:
// segment patterns and an unsigned 8-bit saturating conversion.
package io_util_pkg;

    // Widest signed value the saturator helper accepts; callers sign-extend.
    localparam int SAT_W = 64;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Active-low {g,f,e,d,c,b,a} patterns for 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [7:0] sat_u8(input logic signed [SAT_W-1:0] v);
        logic [7:0] r;
        if (v < 0) begin
            r = 8'd0;
        end else if (v > 255) begin
            r = 8'd255;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/button_sync.sv
// Active-low pushbutton conditioner: 2-flop synchronizer, optional
// debounce (BUTTON_DEBOUNCE_EN), and 1->0 edge detect.
// Ports: clk, reset_n (async, active-low), button (raw, active-low),
//        pressed (one-cycle pulse per press).
module button_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button,
    output logic pressed
);

    if (DEBOUNCE_CYCLES == 0) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be nonzero");
    end

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic       pressed_q;
    logic       pressed_d;
    logic       armed_q;
    logic [1:0] fill_q;
    logic       level;

    // fill_q[1] marks sync2_q as holding a real pin sample rather than
    // the reset value; armed_q then requires a genuine released level,
    // so a key held through reset release gives no pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_q | (fill_q[1] & sync2_q);
        end
    end

`ifdef BUTTON_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          deb_q;
    logic          deb_d;

    // Level only follows sync2_q after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            deb_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign level = deb_q;
`else
    assign level = sync2_q;
`endif

    assign pressed_d = armed_q & prev_q & ~level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= 1'b1;
            pressed_q <= 1'b0;
        end else begin
            prev_q    <= level;
            pressed_q <= pressed_d;
        end
    end

    assign pressed = pressed_q;

endmodule

// File: rtl/button_hex_round.sv
// Board I/O utility: button press pulse, hex to 7-segment, signed to u8.
// Ports: clk, reset_n, button -> pressed; hex_in/hex_blank/hex_neg ->
//        hex_seg; sat_in -> sat_out. Optional macro: BUTTON_DEBOUNCE_EN.
module button_hex_round
    import io_util_pkg::*;
#(
    parameter int          PRECISION       = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        button,
    output logic                        pressed,
    input  logic [3:0]                  hex_in,
    input  logic                        hex_blank,
    input  logic                        hex_neg,
    output logic [6:0]                  hex_seg,
    input  logic signed [PRECISION-1:0] sat_in,
    output logic [7:0]                  sat_out
);

    button_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .button (button),
        .pressed(pressed)
    );

    // Blank wins over minus, minus wins over the digit.
    always_comb begin
        hex_seg = SEG_TABLE[hex_in];
        if (hex_blank) begin
            hex_seg = SEG_BLANK;
        end else if (hex_neg) begin
            hex_seg = SEG_MINUS;
        end
    end

    logic signed [SAT_W-1:0] sat_ext;

    always_comb begin
        sat_ext = {{(SAT_W - PRECISION){sat_in[PRECISION-1]}}, sat_in};
        sat_out = sat_u8(sat_ext);
    end

endmodule

// File: tb/tb_button_hex_round.sv
// Self-checking bench for button_hex_round: table-driven decode and
// saturate vectors plus directed button/reset sequences.
module tb_button_hex_round;

    logic               clk;
    logic               reset_n;
    logic               button;
    logic               pressed;
    logic [3:0]         hex_in;
    logic               hex_blank;
    logic               hex_neg;
    logic [6:0]         hex_seg;
    logic signed [15:0] sat_in;
    logic [7:0]         sat_out;

    int checks = 0;
    int errors = 0;

    button_hex_round #(
        .PRECISION      (16),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .button   (button),
        .pressed  (pressed),
        .hex_in   (hex_in),
        .hex_blank(hex_blank),
        .hex_neg  (hex_neg),
        .hex_seg  (hex_seg),
        .sat_in   (sat_in),
        .sat_out  (sat_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] hin;
        logic       blank;
        logic       neg;
        logic [6:0] seg;
    } hex_vec_t;

    typedef struct {
        logic [15:0] sin;
        logic [7:0]  sout;
    } sat_vec_t;

    hex_vec_t hv [19];
    sat_vec_t sv [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Run n edges, checking pressed after each; pulse expected only on
    // edge number pulse_at (0 = none). Returns the number of pulses seen.
    task automatic watch(input string name, input int n,
                         input int pulse_at, output int pulses);
        pulses = 0;
        for (int i = 1; i <= n; i++) begin
            edge1();
            if (pressed === 1'b1) pulses++;
            check(name, int'(pressed), (i == pulse_at) ? 1 : 0);
        end
    endtask

    initial begin
        int p;

        hv[0]  = '{4'h0, 1'b0, 1'b0, 7'b1000000};
        hv[1]  = '{4'h1, 1'b0, 1'b0, 7'b1111001};
        hv[2]  = '{4'h2, 1'b0, 1'b0, 7'b0100100};
        hv[3]  = '{4'h3, 1'b0, 1'b0, 7'b0110000};
        hv[4]  = '{4'h4, 1'b0, 1'b0, 7'b0011001};
        hv[5]  = '{4'h5, 1'b0, 1'b0, 7'b0010010};
        hv[6]  = '{4'h6, 1'b0, 1'b0, 7'b0000010};
        hv[7]  = '{4'h7, 1'b0, 1'b0, 7'b1111000};
        hv[8]  = '{4'h8, 1'b0, 1'b0, 7'b0000000};
        hv[9]  = '{4'h9, 1'b0, 1'b0, 7'b0010000};
        hv[10] = '{4'hA, 1'b0, 1'b0, 7'b0001000};
        hv[11] = '{4'hB, 1'b0, 1'b0, 7'b0000011};
        hv[12] = '{4'hC, 1'b0, 1'b0, 7'b1000110};
        hv[13] = '{4'hD, 1'b0, 1'b0, 7'b0100001};
        hv[14] = '{4'hE, 1'b0, 1'b0, 7'b0000110};
        hv[15] = '{4'hF, 1'b0, 1'b0, 7'b0001110};
        hv[16] = '{4'h8, 1'b0, 1'b1, 7'b0111111};
        hv[17] = '{4'h8, 1'b1, 1'b1, 7'b1111111};
        hv[18] = '{4'h3, 1'b1, 1'b0, 7'b1111111};

        sv[0] = '{16'hFFFF, 8'd0};
        sv[1] = '{16'h0000, 8'd0};
        sv[2] = '{16'd100,  8'd100};
        sv[3] = '{16'd255,  8'd255};
        sv[4] = '{16'd256,  8'd255};
        sv[5] = '{16'h7FFF, 8'd255};
        sv[6] = '{16'h8000, 8'd0};

        reset_n   = 1'b0;
        button    = 1'b0;
        hex_in    = 4'h0;
        hex_blank = 1'b0;
        hex_neg   = 1'b0;
        sat_in    = '0;

        // Press held during reset and through its release: no pulse.
        #1;
        check("reset_pressed", int'(pressed), 0);
        watch("in_reset", 5, 0, p);
        reset_n = 1'b1;
        watch("held_at_release", 8, 0, p);

        button = 1'b1;
        watch("release_after_reset", 5, 0, p);

        // Normal press: pulse on the third edge only, none on release.
        button = 1'b0;
        watch("press_hold", 20, 3, p);
        check("press_pulse_count", p, 1);
        button = 1'b1;
        watch("release", 8, 0, p);

        // Second press confirms re-arming.
        button = 1'b0;
        watch("press_again", 6, 3, p);
        button = 1'b1;
        watch("release_again", 6, 0, p);

        for (int i = 0; i < 19; i++) begin
            hex_in    = hv[i].hin;
            hex_blank = hv[i].blank;
            hex_neg   = hv[i].neg;
            #1;
            check($sformatf("hex_seg[%0d]", i), int'(hex_seg), int'(hv[i].seg));
        end

        for (int i = 0; i < 7; i++) begin
            sat_in = sv[i].sin;
            #1;
            check($sformatf("sat_out[%0d]", i), int'(sat_out), int'(sv[i].sout));
        end

`ifndef BUTTON_DEBOUNCE_EN
        // Reset lands in the cycle the pulse is high.
        button = 1'b0;
        watch("pre_pulse", 3, 3, p);
        reset_n = 1'b0;
        #1;
        check("reset_kills_pulse", int'(pressed), 0);
        watch("reset_hold", 2, 0, p);
        reset_n = 1'b1;
        watch("after_reset_held", 8, 0, p);
        button = 1'b1;
        watch("release_final", 5, 0, p);
`else
        // Short glitch is filtered, long press gives one pulse at 3+8.
        button = 1'b0;
        watch("glitch_lo", 3, 0, p);
        button = 1'b1;
        watch("glitch_hi", 20, 0, p);
        button = 1'b0;
        watch("long_press", 12, 11, p);
        check("long_press_count", p, 1);
        button = 1'b1;
        watch("long_release", 20, 0, p);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
